// File: rtl/laser_pkg.sv
// Shared types and constants for the player laser pool.
// Optional shot statistics are enabled elsewhere with the LASER_STATS_EN macro.
package laser_pkg;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic   active;
        coord_t x;
        coord_t y;
    } slot_t;

    function automatic coord_t sat_sub(input coord_t a, input coord_t b);
        return (a < b) ? '0 : coord_t'(a - b);
    endfunction

endpackage

// File: rtl/laser_slot.sv
// One laser shot slot: spawn load, upward motion on frame tick, retire on kill or screen top.
module laser_slot
    import laser_pkg::*;
#(
    parameter int unsigned SPEED = 4
) (
    input  logic   Clk,
    input  logic   Reset_n,
    input  logic   spawn,
    input  logic   kill,
    input  logic   tick,
    input  coord_t spawn_x,
    input  coord_t spawn_y,
    output slot_t  state
);

    // Spawn only targets free slots; for a live slot kill wins over motion.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= '0;
        end else if (spawn) begin
            state.active <= 1'b1;
            state.x      <= spawn_x;
            state.y      <= spawn_y;
        end else if (state.active) begin
            if (kill) begin
                state.active <= 1'b0;
            end else if (tick) begin
                if (state.y >= COORD_W'(SPEED)) begin
                    state.y <= state.y - COORD_W'(SPEED);
                end else begin
                    state.active <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/laser_pool.sv
// Laser shot pool: frame sync, fire edge/cooldown, slot allocation and pixel hit mux.
// Define LASER_STATS_EN to build the accepted-shot counter; otherwise shots_fired is zero.
module laser_pool
    import laser_pkg::*;
#(
    parameter int unsigned NUM_LASERS  = 4,
    parameter int unsigned SPEED       = 4,
    parameter int unsigned SPRITE_SIZE = 16,
    parameter int unsigned COOLDOWN    = 8
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       frame_clk,
    input  logic                       fire,
    input  logic [9:0]                 player_x,
    input  logic [9:0]                 player_y,
    input  logic                       kill_valid,
    input  logic [2:0]                 kill_idx,
    input  logic [9:0]                 DrawX,
    input  logic [9:0]                 DrawY,
    input  logic                       sprite_bit,
    output logic [9:0]                 sprite_x,
    output logic [9:0]                 sprite_y,
    output logic                       laser_on,
    output logic [NUM_LASERS-1:0]      active_mask,
    output logic [NUM_LASERS*10-1:0]   laser_x,
    output logic [NUM_LASERS*10-1:0]   laser_y,
    output logic                       fire_drop,
    output logic [15:0]                shots_fired
);

    localparam int unsigned CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    slot_t                 slots [NUM_LASERS];
    logic [2:0]            frame_sync;
    logic                  tick;
    logic                  fire_q;
    logic [CD_W-1:0]       cooldown;
    logic                  rise;
    logic                  free_found;
    logic [NUM_LASERS-1:0] free_oh;
    logic                  accept;
    logic                  hit;

    assign rise   = fire & ~fire_q;
    assign accept = rise && (cooldown == '0) && free_found;

    // frame_sync[1:0] resynchronise frame_clk; frame_sync[2] is the edge reference.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_sync <= '0;
            tick       <= 1'b0;
            fire_q     <= 1'b0;
            cooldown   <= '0;
            fire_drop  <= 1'b0;
        end else begin
            frame_sync <= {frame_sync[1:0], frame_clk};
            tick       <= frame_sync[1] & ~frame_sync[2];
            fire_q     <= fire;
            fire_drop  <= rise & ~accept;
            if (accept) begin
                cooldown <= CD_W'(COOLDOWN);
            end else if (tick && cooldown != '0) begin
                cooldown <= cooldown - 1'b1;
            end
        end
    end

    always_comb begin
        free_oh    = '0;
        free_found = 1'b0;
        for (int i = 0; i < NUM_LASERS; i++) begin
            if (!free_found && !slots[i].active) begin
                free_oh[i] = 1'b1;
                free_found = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_LASERS; i++) begin : g_slot
        laser_slot #(
            .SPEED (SPEED)
        ) u_slot (
            .Clk     (Clk),
            .Reset_n (Reset_n),
            .spawn   (accept & free_oh[i]),
            .kill    (kill_valid && (kill_idx == 3'(i))),
            .tick    (tick),
            .spawn_x (player_x),
            .spawn_y (sat_sub(player_y, COORD_W'(SPRITE_SIZE))),
            .state   (slots[i])
        );

        assign active_mask[i]       = slots[i].active;
        assign laser_x[i*10 +: 10]  = slots[i].x;
        assign laser_y[i*10 +: 10]  = slots[i].y;
    end

    // Scan high to low so the lowest-index hit is the one left standing.
    always_comb begin
        hit      = 1'b0;
        sprite_x = '0;
        sprite_y = '0;
        for (int i = NUM_LASERS - 1; i >= 0; i--) begin
            if (slots[i].active &&
                ({1'b0, DrawX} >= {1'b0, slots[i].x}) &&
                ({1'b0, DrawX} <  {1'b0, slots[i].x} + 11'(SPRITE_SIZE)) &&
                ({1'b0, DrawY} >= {1'b0, slots[i].y}) &&
                ({1'b0, DrawY} <  {1'b0, slots[i].y} + 11'(SPRITE_SIZE))) begin
                hit      = 1'b1;
                sprite_x = DrawX - slots[i].x;
                sprite_y = DrawY - slots[i].y;
            end
        end
    end

    assign laser_on = hit & sprite_bit;

`ifdef LASER_STATS_EN
    logic [15:0] shot_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shot_cnt <= '0;
        end else if (accept) begin
            shot_cnt <= shot_cnt + 16'd1;
        end
    end

    assign shots_fired = shot_cnt;
`else
    assign shots_fired = 16'h0;
`endif

endmodule

// File: tb/tb_laser_pool.sv
// Directed self-checking bench for laser_pool with default parameters.
module tb_laser_pool;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic        fire = 1'b0;
    logic [9:0]  player_x = '0;
    logic [9:0]  player_y = '0;
    logic        kill_valid = 1'b0;
    logic [2:0]  kill_idx = '0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        sprite_bit = 1'b0;
    logic [9:0]  sprite_x;
    logic [9:0]  sprite_y;
    logic        laser_on;
    logic [3:0]  active_mask;
    logic [39:0] laser_x;
    logic [39:0] laser_y;
    logic        fire_drop;
    logic [15:0] shots_fired;

    int errors = 0;
    int checks = 0;

`ifdef LASER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    laser_pool dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .fire        (fire),
        .player_x    (player_x),
        .player_y    (player_y),
        .kill_valid  (kill_valid),
        .kill_idx    (kill_idx),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .sprite_bit  (sprite_bit),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .laser_on    (laser_on),
        .active_mask (active_mask),
        .laser_x     (laser_x),
        .laser_y     (laser_y),
        .fire_drop   (fire_drop),
        .shots_fired (shots_fired)
    );

    always #5 Clk = ~Clk;

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic frame_tick();
        @(negedge Clk);
        frame_clk = 1'b1;
        step(4);
        frame_clk = 1'b0;
        step(3);
    endtask

    task automatic ticks(input int n);
        repeat (n) frame_tick();
    endtask

    task automatic fire_shot(output logic drop);
        @(negedge Clk);
        fire = 1'b1;
        @(negedge Clk);
        drop = fire_drop;
        fire = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (active_mask !== 4'h0) begin
            errors++; $display("FAIL reset_mask got=%h exp=0", active_mask);
        end
        checks++;
        if (shots_fired !== 16'h0) begin
            errors++; $display("FAIL reset_shots got=%h exp=0", shots_fired);
        end
        checks++;
        if (fire_drop !== 1'b0 || laser_on !== 1'b0) begin
            errors++; $display("FAIL reset_outs got=%b%b exp=00", fire_drop, laser_on);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        step(2);
    endtask

    task automatic test_spawn_move_pixel();
        logic drop;
        player_x = 10'd100;
        player_y = 10'd200;
        fire_shot(drop);
        checks++;
        if (drop !== 1'b0 || active_mask !== 4'b0001) begin
            errors++; $display("FAIL spawn got drop=%b mask=%h exp drop=0 mask=1", drop, active_mask);
        end
        checks++;
        if (laser_x[9:0] !== 10'd100 || laser_y[9:0] !== 10'd184) begin
            errors++; $display("FAIL spawn_xy got=(%0d,%0d) exp=(100,184)", laser_x[9:0], laser_y[9:0]);
        end
        frame_tick();
        checks++;
        if (laser_y[9:0] !== 10'd180) begin
            errors++; $display("FAIL tick_move got=%0d exp=180", laser_y[9:0]);
        end
        DrawX = 10'd107; DrawY = 10'd186; sprite_bit = 1'b1;
        #1;
        checks++;
        if (sprite_x !== 10'd7 || sprite_y !== 10'd6 || laser_on !== 1'b1) begin
            errors++; $display("FAIL pixel_hit got=(%0d,%0d,%b) exp=(7,6,1)", sprite_x, sprite_y, laser_on);
        end
        sprite_bit = 1'b0;
        #1;
        checks++;
        if (laser_on !== 1'b0) begin
            errors++; $display("FAIL pixel_bit_gate got=%b exp=0", laser_on);
        end
        DrawX = 10'd115; DrawY = 10'd195; sprite_bit = 1'b1;
        #1;
        checks++;
        if (sprite_x !== 10'd15 || sprite_y !== 10'd15 || laser_on !== 1'b1) begin
            errors++; $display("FAIL pixel_corner got=(%0d,%0d,%b) exp=(15,15,1)", sprite_x, sprite_y, laser_on);
        end
        DrawX = 10'd116;
        #1;
        checks++;
        if (sprite_x !== 10'd0 || sprite_y !== 10'd0 || laser_on !== 1'b0) begin
            errors++; $display("FAIL pixel_edge got=(%0d,%0d,%b) exp=(0,0,0)", sprite_x, sprite_y, laser_on);
        end
        DrawX = 10'd115; DrawY = 10'd196;
        #1;
        checks++;
        if (laser_on !== 1'b0) begin
            errors++; $display("FAIL pixel_bottom got=%b exp=0", laser_on);
        end
    endtask

    task automatic test_cooldown();
        logic drop;
        fire_shot(drop);
        checks++;
        if (drop !== 1'b1 || active_mask !== 4'b0001) begin
            errors++; $display("FAIL cooldown_drop got drop=%b mask=%h exp drop=1 mask=1", drop, active_mask);
        end
        checks++;
        if (fire_drop !== 1'b0) begin
            errors++; $display("FAIL drop_pulse got=%b exp=0", fire_drop);
        end
        ticks(7);
        fire_shot(drop);
        checks++;
        if (drop !== 1'b0 || active_mask !== 4'b0011) begin
            errors++; $display("FAIL cooldown_expired got drop=%b mask=%h exp drop=0 mask=3", drop, active_mask);
        end
        checks++;
        if (laser_y[9:0] !== 10'd152 || laser_y[19:10] !== 10'd184) begin
            errors++; $display("FAIL cooldown_y got=(%0d,%0d) exp=(152,184)", laser_y[9:0], laser_y[19:10]);
        end
    endtask

    task automatic test_held_fire();
        int drops = 0;
        ticks(8);
        @(negedge Clk);
        fire = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (fire_drop === 1'b1) drops++;
        end
        fire = 1'b0;
        step(1);
        checks++;
        if (active_mask !== 4'b0111 || drops != 0) begin
            errors++; $display("FAIL held_fire got mask=%h drops=%0d exp mask=7 drops=0", active_mask, drops);
        end
        checks++;
        if (laser_y[29:20] !== 10'd184 || laser_y[9:0] !== 10'd120) begin
            errors++; $display("FAIL held_y got=(%0d,%0d) exp=(184,120)", laser_y[29:20], laser_y[9:0]);
        end
    endtask

    task automatic test_fill();
        logic drop;
        ticks(8);
        fire_shot(drop);
        checks++;
        if (drop !== 1'b0 || active_mask !== 4'hF) begin
            errors++; $display("FAIL fill_last got drop=%b mask=%h exp drop=0 mask=F", drop, active_mask);
        end
        ticks(8);
        fire_shot(drop);
        checks++;
        if (drop !== 1'b1 || active_mask !== 4'hF) begin
            errors++; $display("FAIL fill_full got drop=%b mask=%h exp drop=1 mask=F", drop, active_mask);
        end
        checks++;
        if (laser_y[9:0] !== 10'd56 || laser_y[39:30] !== 10'd152) begin
            errors++; $display("FAIL fill_y got=(%0d,%0d) exp=(56,152)", laser_y[9:0], laser_y[39:30]);
        end
        checks++;
        if (shots_fired !== (STATS ? 16'd4 : 16'd0)) begin
            errors++; $display("FAIL shots_4 got=%0d exp=%0d", shots_fired, STATS ? 4 : 0);
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (active_mask !== 4'h0 || shots_fired !== 16'h0) begin
            errors++; $display("FAIL async_reset got mask=%h shots=%0d exp 0/0", active_mask, shots_fired);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        step(2);
    endtask

    task automatic test_saturate_retire();
        logic drop;
        player_x = 10'd300;
        player_y = 10'd10;
        fire_shot(drop);
        checks++;
        if (active_mask !== 4'b0001 || laser_y[9:0] !== 10'd0 || laser_x[9:0] !== 10'd300) begin
            errors++; $display("FAIL saturate got mask=%h y=%0d x=%0d exp 1/0/300", active_mask, laser_y[9:0], laser_x[9:0]);
        end
        frame_tick();
        checks++;
        if (active_mask !== 4'b0000) begin
            errors++; $display("FAIL top_retire got=%h exp=0", active_mask);
        end
    endtask

    task automatic test_kill();
        logic drop;
        ticks(7);
        player_x = 10'd200;
        player_y = 10'd300;
        fire_shot(drop);
        ticks(8);
        fire_shot(drop);
        checks++;
        if (active_mask !== 4'b0011) begin
            errors++; $display("FAIL kill_setup got=%h exp=3", active_mask);
        end
        @(negedge Clk);
        frame_clk = 1'b1;
        step(3);
        kill_valid = 1'b1;
        kill_idx = 3'd1;
        step(1);
        kill_valid = 1'b0;
        frame_clk = 1'b0;
        step(3);
        checks++;
        if (active_mask !== 4'b0001 || laser_y[9:0] !== 10'd248 || laser_y[19:10] !== 10'd284) begin
            errors++; $display("FAIL kill_vs_tick got mask=%h y0=%0d y1=%0d exp 1/248/284",
                               active_mask, laser_y[9:0], laser_y[19:10]);
        end
        @(negedge Clk);
        kill_valid = 1'b1;
        kill_idx = 3'd5;
        @(negedge Clk);
        kill_idx = 3'd1;
        @(negedge Clk);
        kill_valid = 1'b0;
        checks++;
        if (active_mask !== 4'b0001) begin
            errors++; $display("FAIL kill_ignored got=%h exp=1", active_mask);
        end
        kill_valid = 1'b1;
        kill_idx = 3'd0;
        @(negedge Clk);
        kill_valid = 1'b0;
        checks++;
        if (active_mask !== 4'b0000) begin
            errors++; $display("FAIL kill_slot0 got=%h exp=0", active_mask);
        end
    endtask

    task automatic test_overlap();
        logic drop;
        ticks(7);
        player_x = 10'd400;
        player_y = 10'd100;
        fire_shot(drop);
        ticks(8);
        fire_shot(drop);
        ticks(8);
        player_x = 10'd404;
        player_y = 10'd38;
        fire_shot(drop);
        checks++;
        if (active_mask !== 4'b0111 || laser_y[9:0] !== 10'd20 || laser_y[29:20] !== 10'd22 ||
            laser_x[29:20] !== 10'd404) begin
            errors++; $display("FAIL overlap_setup got mask=%h y0=%0d y2=%0d x2=%0d exp 7/20/22/404",
                               active_mask, laser_y[9:0], laser_y[29:20], laser_x[29:20]);
        end
        DrawX = 10'd410; DrawY = 10'd30; sprite_bit = 1'b1;
        #1;
        checks++;
        if (sprite_x !== 10'd10 || sprite_y !== 10'd10 || laser_on !== 1'b1) begin
            errors++; $display("FAIL overlap_prio got=(%0d,%0d,%b) exp=(10,10,1)", sprite_x, sprite_y, laser_on);
        end
        @(negedge Clk);
        kill_valid = 1'b1;
        kill_idx = 3'd0;
        @(negedge Clk);
        kill_valid = 1'b0;
        #1;
        checks++;
        if (sprite_x !== 10'd6 || sprite_y !== 10'd8 || laser_on !== 1'b1) begin
            errors++; $display("FAIL overlap_next got=(%0d,%0d,%b) exp=(6,8,1)", sprite_x, sprite_y, laser_on);
        end
        checks++;
        if (shots_fired !== (STATS ? 16'd6 : 16'd0)) begin
            errors++; $display("FAIL shots_6 got=%0d exp=%0d", shots_fired, STATS ? 6 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_spawn_move_pixel();
        test_cooldown();
        test_held_fire();
        test_fill();
        test_reset_midflight();
        test_saturate_retire();
        test_kill();
        test_overlap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
